clk_div_gen: RTL and testbench

- Parametrised, runtime-programmable clock divider, successor to the fixed divide-by-2 counter.
- Generates a registered divided clock `dclk` (near-50% duty, any integer ratio ≥1) and a one-cycle `tick` enable from the fast `clk_small` domain.
- Sits in the clocking/top level and feeds the slow-clock pipeline and timer logic.
- Divisor changes are glitch-free: a new divisor applies only at a period boundary.

---
 rtl/clk_div_gen_if.sv | 25 ++
 rtl/clk_div_gen.sv | 88 ++++++++
 tb/tb_clk_div_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_gen_if.sv
// Control and status bundle for the programmable clock divider.
// The master drives the divisor controls; the slave (divider) returns its registered state.
interface clk_div_gen_if #(
   parameter int unsigned CNT_W = 8
);
   logic             en;
   logic [CNT_W-1:0] div_in;
   logic             div_load;
   logic             dclk;
   logic             tick;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] div_cur;
   logic             pending;
   logic             load_err;

   modport master (
      output en, div_in, div_load,
      input  dclk, tick, counter, div_cur, pending, load_err
   );

   modport slave (
      input  en, div_in, div_load,
      output dclk, tick, counter, div_cur, pending, load_err
   );
endinterface

// File: rtl/clk_div_gen.sv
// Runtime-programmable integer clock divider with near-50% duty dclk and a per-period tick.
// A new divisor takes effect only at a period boundary, so no runt phase is produced.
module clk_div_gen #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned DEF_DIV = 2
) (
   input logic          clk_small,
   input logic          rst,
   clk_div_gen_if.slave bus
);
   localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cur_q, cur_d;
   logic [CNT_W-1:0] nxt_q, nxt_d;
   logic             dclk_q, dclk_d;
   logic             tick_q, tick_d;
   logic             pend_q, pend_d;
   logic             err_q, err_d;

   logic             load_ok;
   logic             wrap;
   logic [CNT_W-1:0] div_new;
   logic [CNT_W:0]   half;

   always_comb begin
      load_ok = bus.div_load && (bus.div_in != '0);
      wrap    = bus.en && (cnt_q == cur_q - 1'b1);

      cnt_d   = cnt_q;
      dclk_d  = dclk_q;
      tick_d  = 1'b0;
      cur_d   = cur_q;
      nxt_d   = nxt_q;
      pend_d  = pend_q;
      err_d   = bus.div_load && (bus.div_in == '0);
      div_new = cur_q;

      // A load landing on the wrap cycle beats any older pending divisor
      if (wrap) begin
         if (load_ok) begin
            div_new = bus.div_in;
         end else if (pend_q) begin
            div_new = nxt_q;
         end
         cur_d  = div_new;
         pend_d = 1'b0;
      end else if (load_ok) begin
         nxt_d  = bus.div_in;
         pend_d = 1'b1;
      end

      half = ({1'b0, div_new} + (CNT_W + 1)'(1)) >> 1;

      if (bus.en) begin
         cnt_d  = wrap ? '0 : cnt_q + 1'b1;
         dclk_d = ({1'b0, cnt_d} < half);
         tick_d = (cnt_d == '0);
      end
   end

   always_ff @(posedge clk_small) begin
      if (!rst) begin
         cnt_q  <= DefDiv - 1'b1;
         cur_q  <= DefDiv;
         nxt_q  <= DefDiv;
         dclk_q <= 1'b0;
         tick_q <= 1'b0;
         pend_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         cur_q  <= cur_d;
         nxt_q  <= nxt_d;
         dclk_q <= dclk_d;
         tick_q <= tick_d;
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end

   assign bus.dclk     = dclk_q;
   assign bus.tick     = tick_q;
   assign bus.counter  = cnt_q;
   assign bus.div_cur  = cur_q;
   assign bus.pending  = pend_q;
   assign bus.load_err = err_q;
endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: a cycle model queues expected state on every drive,
// which is popped and compared one edge later, plus waveform shape checks.
module tb_clk_div_gen;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned DEF_DIV = 2;

   typedef struct {
      logic [CNT_W-1:0] cnt;
      logic             dclk;
      logic             tick;
      logic [CNT_W-1:0] cur;
      logic             pend;
      logic             err;
   } exp_t;

   logic clk_small = 1'b0;
   logic rst       = 1'b0;

   clk_div_gen_if #(.CNT_W(CNT_W)) bus ();

   clk_div_gen #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .clk_small (clk_small),
      .rst       (rst),
      .bus       (bus)
   );

   always #5 clk_small = ~clk_small;

   exp_t sb[$];
   exp_t m;
   int   m_nxt;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   meas  = 1'b0;
   int   hi_n  = 0;
   int   tk_n  = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask

   // Reference behaviour written in period terms: high while phase < ceil(D/2)
   task automatic model(input logic r, input logic e, input int d, input logic l);
      bit ok;
      bit wr;
      int dn;
      if (!r) begin
         m.cnt = CNT_W'(DEF_DIV - 1); m.dclk = 0; m.tick = 0;
         m.cur = CNT_W'(DEF_DIV); m.pend = 0; m.err = 0; m_nxt = DEF_DIV;
         return;
      end
      ok    = l && (d != 0);
      m.err = l && (d == 0);
      wr    = e && (int'(m.cnt) == int'(m.cur) - 1);
      if (wr) begin
         dn     = ok ? d : (m.pend ? m_nxt : int'(m.cur));
         m.cur  = CNT_W'(dn);
         m.pend = 0;
      end else if (ok) begin
         m_nxt  = d;
         m.pend = 1;
      end
      if (e) begin
         m.cnt  = wr ? '0 : m.cnt + 1'b1;
         m.dclk = (int'(m.cnt) < (int'(m.cur) + 1) / 2);
         m.tick = (m.cnt == 0);
      end else begin
         m.tick = 0;
      end
   endtask

   task automatic step(input logic r, input logic e, input int d, input logic l);
      exp_t x;
      rst          = r;
      bus.en       = e;
      bus.div_in   = CNT_W'(d);
      bus.div_load = l;
      model(r, e, d, l);
      sb.push_back(m);
      @(posedge clk_small);
      #1;
      x = sb.pop_front();
      check_val("counter",  32'(bus.counter),  32'(x.cnt));
      check_val("dclk",     32'(bus.dclk),     32'(x.dclk));
      check_val("tick",     32'(bus.tick),     32'(x.tick));
      check_val("div_cur",  32'(bus.div_cur),  32'(x.cur));
      check_val("pending",  32'(bus.pending),  32'(x.pend));
      check_val("load_err", 32'(bus.load_err), 32'(x.err));
      if (meas) begin
         hi_n += int'(bus.dclk);
         tk_n += int'(bus.tick);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 0, 1'b0);
   endtask

   task automatic wait_cnt(input int c);
      int k = 0;
      while (int'(m.cnt) != c && k < 20) begin
         step(1'b1, 1'b1, 0, 1'b0);
         k++;
      end
      check_val("wait_cnt", 32'(m.cnt), 32'(c));
   endtask

   task automatic measure(input string tag, input int n, input int hi_exp, input int tk_exp);
      hi_n = 0;
      tk_n = 0;
      meas = 1'b1;
      run(n);
      meas = 1'b0;
      check_val({tag, "_high"}, 32'(hi_n), 32'(hi_exp));
      check_val({tag, "_ticks"}, 32'(tk_n), 32'(tk_exp));
   endtask

   initial begin
      bus.en       = 1'b0;
      bus.div_in   = '0;
      bus.div_load = 1'b0;
      m_nxt        = DEF_DIV;

      step(1'b0, 1'b1, 0, 1'b0);
      step(1'b0, 1'b1, 0, 1'b0);
      check_val("rst_counter", 32'(bus.counter), 32'(DEF_DIV - 1));
      check_val("rst_div_cur", 32'(bus.div_cur), 32'(DEF_DIV));
      measure("d2", 8, 4, 4);

      // Divide by 5: 3 high + 2 low per period
      wait_cnt(0);
      step(1'b1, 1'b1, 5, 1'b1);
      check_val("d5_pending", 32'(bus.pending), 32'd1);
      run(1);
      check_val("d5_div_cur", 32'(bus.div_cur), 32'd5);
      measure("d5", 10, 6, 2);

      // Divide by 1: dclk constantly high
      step(1'b1, 1'b1, 1, 1'b1);
      run(6);
      measure("d1", 5, 5, 5);

      // Mid-period change from 6 to 4
      step(1'b1, 1'b1, 6, 1'b1);
      run(3);
      wait_cnt(2);
      step(1'b1, 1'b1, 4, 1'b1);
      run(3);
      check_val("d6_end_div_cur", 32'(bus.div_cur), 32'd4);
      measure("d4", 8, 4, 2);

      // Rejected zero load, then last-writer-wins
      wait_cnt(1);
      step(1'b1, 1'b1, 0, 1'b1);
      check_val("err_pulse", 32'(bus.load_err), 32'd1);
      run(1);
      check_val("err_clear", 32'(bus.load_err), 32'd0);
      wait_cnt(0);
      step(1'b1, 1'b1, 3, 1'b1);
      step(1'b1, 1'b1, 7, 1'b1);
      run(8);
      check_val("last_wins", 32'(bus.div_cur), 32'd7);

      // Freeze with en=0, loading a divisor while frozen
      wait_cnt(2);
      step(1'b1, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 3, 1'b1);
      step(1'b1, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 0, 1'b0);
      check_val("frozen_cnt", 32'(bus.counter), 32'd2);
      run(3);

      // Reset with a divisor pending
      wait_cnt(0);
      step(1'b1, 1'b1, 9, 1'b1);
      step(1'b0, 1'b1, 0, 1'b0);
      check_val("rst_pending", 32'(bus.pending), 32'd0);
      run(6);
      check_val("rst_discard", 32'(bus.div_cur), 32'(DEF_DIV));

      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
              int'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
